// File: rtl/uart_bus_bridge.sv
// UART 8N1 debug bridge: decodes 'W'/'R' command frames into single 32-bit bus
// transactions and returns ACK/NAK (plus read data) over the same link.
module uart_bus_bridge #(
    parameter int CLKS_PER_BIT = 868,
    parameter int RD_TIMEOUT   = 1024
) (
    input  logic        clk_100mhz,
    input  logic        rstn_i,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_bus_stb,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_data,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_data_ready,
    output logic        o_busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RD_TIMEOUT - 1);
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_GET_ADDR   = 3'd1,
        S_GET_DATA   = 3'd2,
        S_BUS_WR     = 3'd3,
        S_BUS_RD     = 3'd4,
        S_SEND_REPLY = 3'd5
    } state_t;

    logic             rx_meta_r, rx_sync_r, rx_prev_r;
    logic             rx_active_r, rx_valid_r, rx_ferr_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [3:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;

    state_t           state_r, next_state_s;
    logic             is_write_r;
    logic [1:0]       byte_cnt_r;
    logic [31:0]      addr_shift_r, data_shift_r;
    logic [31:0]      bus_addr_r, bus_data_r;
    logic             bus_stb_r, bus_we_r, busy_r;
    logic             bus_stb_s, bus_we_s, busy_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [39:0]      reply_r;
    logic [2:0]       reply_left_r;

    logic             tx_busy_r, tx_line_r, tx_load_s, tx_end_s, rd_timeout_s;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [3:0]       tx_bit_r;
    logic [8:0]       tx_data_r;

    assign o_uart_tx  = tx_line_r;
    assign o_bus_stb  = bus_stb_r;
    assign o_bus_we   = bus_we_r;
    assign o_bus_addr = bus_addr_r;
    assign o_bus_data = bus_data_r;
    assign o_busy     = busy_r;

    assign tx_end_s     = tx_busy_r && (tx_cnt_r == {CNT_W{1'b0}}) && (tx_bit_r == 4'd9);
    assign rd_timeout_s = (to_cnt_r == TO_LAST);

    // Two-flop synchronizer plus previous sample for falling-edge detection
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= i_uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX bit engine: start re-check at half bit, then mid-bit sampling, LSB first
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_active_r <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_ferr_r   <= 1'b0;
            rx_cnt_r    <= {CNT_W{1'b0}};
            rx_bit_r    <= 4'd0;
            rx_shift_r  <= 8'h00;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            if (!rx_active_r) begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_active_r <= 1'b1;
                    rx_cnt_r    <= HALF_LAST;
                    rx_bit_r    <= 4'd0;
                end
            end else if (rx_cnt_r != {CNT_W{1'b0}}) begin
                rx_cnt_r <= rx_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                rx_cnt_r <= BIT_LAST;
                case (rx_bit_r)
                    4'd0: begin
                        if (rx_sync_r) rx_active_r <= 1'b0;
                        else           rx_bit_r    <= 4'd1;
                    end
                    4'd9: begin
                        rx_active_r <= 1'b0;
                        rx_valid_r  <= rx_sync_r;
                        rx_ferr_r   <= !rx_sync_r;
                    end
                    default: begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 4'd1;
                    end
                endcase
            end
        end
    end

    // Control state register
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) state_r <= S_IDLE;
        else         state_r <= next_state_s;
    end

    // Control next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!rx_valid_r)                                          next_state_s = S_IDLE;
                else if ((rx_shift_r == CMD_WR) || (rx_shift_r == CMD_RD)) next_state_s = S_GET_ADDR;
                else                                                      next_state_s = S_SEND_REPLY;
            end
            S_GET_ADDR: begin
                if (rx_ferr_r)                                 next_state_s = S_IDLE;
                else if (rx_valid_r && (byte_cnt_r == 2'd3))   next_state_s = is_write_r ? S_GET_DATA : S_BUS_RD;
                else                                           next_state_s = S_GET_ADDR;
            end
            S_GET_DATA: begin
                if (rx_ferr_r)                                 next_state_s = S_IDLE;
                else if (rx_valid_r && (byte_cnt_r == 2'd3))   next_state_s = S_BUS_WR;
                else                                           next_state_s = S_GET_DATA;
            end
            S_BUS_WR: next_state_s = S_SEND_REPLY;
            S_BUS_RD: begin
                if (i_bus_data_ready || rd_timeout_s) next_state_s = S_SEND_REPLY;
                else                                  next_state_s = S_BUS_RD;
            end
            S_SEND_REPLY: begin
                if (tx_end_s && (reply_left_r == 3'd0)) next_state_s = S_IDLE;
                else                                    next_state_s = S_SEND_REPLY;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Control outputs, decoded from the upcoming state so the registers line up with it
    always_comb begin
        bus_stb_s = (next_state_s == S_BUS_WR) || (next_state_s == S_BUS_RD);
        bus_we_s  = (next_state_s == S_BUS_WR);
        busy_s    = (next_state_s != S_IDLE);
        tx_load_s = (state_r == S_SEND_REPLY) && (reply_left_r != 3'd0) && (!tx_busy_r || tx_end_s);
    end

    // Frame assembly, bus registers, read timeout and reply buffer
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            is_write_r   <= 1'b0;
            byte_cnt_r   <= 2'd0;
            addr_shift_r <= 32'h0;
            data_shift_r <= 32'h0;
            bus_addr_r   <= 32'h0;
            bus_data_r   <= 32'h0;
            bus_stb_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
            reply_r      <= 40'h0;
            reply_left_r <= 3'd0;
        end else begin
            bus_stb_r <= bus_stb_s;
            bus_we_r  <= bus_we_s;
            busy_r    <= busy_s;
            to_cnt_r  <= (state_r == S_BUS_RD) ? to_cnt_r + TO_W'(1) : {TO_W{1'b0}};
            if ((state_r == S_GET_ADDR) && (next_state_s == S_BUS_RD)) begin
                bus_addr_r <= {addr_shift_r[23:0], rx_shift_r};
            end else if ((state_r == S_GET_DATA) && (next_state_s == S_BUS_WR)) begin
                bus_addr_r <= addr_shift_r;
                bus_data_r <= {data_shift_r[23:0], rx_shift_r};
            end
            case (state_r)
                S_IDLE: begin
                    byte_cnt_r <= 2'd0;
                    if (rx_valid_r) begin
                        is_write_r   <= (rx_shift_r == CMD_WR);
                        reply_r      <= {NAK, 32'h0};
                        reply_left_r <= 3'd1;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_valid_r) begin
                        addr_shift_r <= {addr_shift_r[23:0], rx_shift_r};
                        byte_cnt_r   <= byte_cnt_r + 2'd1;
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid_r) begin
                        data_shift_r <= {data_shift_r[23:0], rx_shift_r};
                        byte_cnt_r   <= byte_cnt_r + 2'd1;
                    end
                end
                S_BUS_WR: begin
                    reply_r      <= {ACK, 32'h0};
                    reply_left_r <= 3'd1;
                end
                S_BUS_RD: begin
                    if (i_bus_data_ready) begin
                        reply_r      <= {ACK, i_bus_data};
                        reply_left_r <= 3'd5;
                    end else if (rd_timeout_s) begin
                        reply_r      <= {NAK, 32'h0};
                        reply_left_r <= 3'd1;
                    end
                end
                S_SEND_REPLY: begin
                    if (tx_load_s) begin
                        reply_r      <= {reply_r[31:0], 8'h00};
                        reply_left_r <= reply_left_r - 3'd1;
                    end
                end
                default: begin
                    byte_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // TX engine: a new byte may load in the last stop-bit cycle, giving back-to-back frames
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_busy_r <= 1'b0;
            tx_line_r <= 1'b1;
            tx_cnt_r  <= {CNT_W{1'b0}};
            tx_bit_r  <= 4'd0;
            tx_data_r <= 9'h1FF;
        end else if (tx_load_s) begin
            tx_busy_r <= 1'b1;
            tx_line_r <= 1'b0;
            tx_cnt_r  <= BIT_LAST;
            tx_bit_r  <= 4'd0;
            tx_data_r <= {1'b1, reply_r[39:32]};
        end else if (tx_busy_r) begin
            if (tx_cnt_r != {CNT_W{1'b0}}) begin
                tx_cnt_r <= tx_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (tx_bit_r == 4'd9) begin
                tx_busy_r <= 1'b0;
            end else begin
                tx_line_r <= tx_data_r[0];
                tx_data_r <= {1'b1, tx_data_r[8:1]};
                tx_bit_r  <= tx_bit_r + 4'd1;
                tx_cnt_r  <= BIT_LAST;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus cycles and
// reply bytes; independent monitors on the bus and TX line pop and compare.
module tb_uart_bus_bridge;
    localparam int CPB  = 8;
    localparam int RDTO = 16;

    logic        clk, rstn, rx, tx, stb, we, rdy, busy;
    logic [31:0] addr, wdata, rdata;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;   // expected strobe cycles; 0 = aborted, not checked
    } bus_exp_t;
    typedef struct {
        logic [7:0] b;
        logic       last;
    } tx_exp_t;

    bus_exp_t exp_bus_q[$];
    tx_exp_t  exp_tx_q[$];

    int          rd_lat = -1;
    logic [31:0] rd_word = 32'h0;

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .RD_TIMEOUT(RDTO)) dut (
        .clk_100mhz(clk), .rstn_i(rstn), .i_uart_rx(rx), .o_uart_tx(tx),
        .o_bus_stb(stb), .o_bus_we(we), .o_bus_addr(addr), .o_bus_data(wdata),
        .i_bus_data(rdata), .i_bus_data_ready(rdy), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus responder: ready after rd_lat strobe cycles; random noise on ready outside reads
    int rsp_k = 0;
    always @(negedge clk) begin
        if (stb === 1'b1 && we === 1'b0) begin
            rdy   = (rsp_k == rd_lat);
            rdata = (rsp_k == rd_lat) ? rd_word : $urandom;
            rsp_k++;
        end else begin
            rsp_k = 0;
            rdy   = 1'($urandom_range(0, 1));
            rdata = $urandom;
        end
    end

    // Bus monitor
    bus_exp_t cur_bus;
    logic     stb_prev = 1'b0;
    int       stb_len  = 0;
    always @(negedge clk) begin
        if (stb === 1'b1 && stb_prev !== 1'b1) begin
            if (exp_bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: strobe at addr %h, expected no strobe", addr);
                cur_bus.len = 0;
            end else begin
                cur_bus = exp_bus_q.pop_front();
                check("bus_we", 32'(we), 32'(cur_bus.we));
                check("bus_addr", addr, cur_bus.addr);
                if (cur_bus.we) check("bus_wdata", wdata, cur_bus.data);
            end
            stb_len = 1;
        end else if (stb === 1'b1) begin
            stb_len++;
        end else if (stb_prev === 1'b1 && cur_bus.len != 0) begin
            check("bus_stb_cycles", stb_len, cur_bus.len);
        end
        stb_prev = stb;
    end

    // TX monitor: decodes 8N1 at mid-bit, checks back-to-back spacing and o_busy release
    always begin : tx_mon
        tx_exp_t    e;
        logic [7:0] b;
        logic       more;
        @(negedge clk);
        if (rstn === 1'b1 && tx === 1'b0) begin
            more = 1'b1;
            while (more) begin
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", 32'(tx), 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 32'(tx), 32'h1);
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h, expected no reply", b);
                    e.last = 1'b1;
                end else begin
                    e = exp_tx_q.pop_front();
                    check("tx_byte", 32'(b), 32'(e.b));
                end
                if (e.last) begin
                    repeat (CPB / 2 - 1) @(negedge clk);
                    check("busy_during_stop", 32'(busy), 32'h1);
                    @(negedge clk);
                    check("busy_after_stop", 32'(busy), 32'h0);
                    more = 1'b0;
                end else begin
                    repeat (CPB / 2) @(negedge clk);
                    check("tx_back_to_back", 32'(tx), 32'h0);
                    more = (tx === 1'b0);
                end
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) uart_send(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_bus_q.size() != 0 || exp_tx_q.size() != 0 || busy !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < 4000) ? 32'h0 : 32'h1, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        exp_bus_q.push_back('{1'b1, a, d, 1});
        exp_tx_q.push_back('{8'h06, 1'b1});
        uart_send(8'h57, 1'b1);
        send_word(a);
        send_word(d);
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input logic [31:0] d);
        rd_lat  = lat;
        rd_word = d;
        exp_bus_q.push_back('{1'b0, a, 32'h0, (lat < 0) ? RDTO : lat + 1});
        if (lat < 0) begin
            exp_tx_q.push_back('{8'h15, 1'b1});
        end else begin
            exp_tx_q.push_back('{8'h06, 1'b0});
            for (int i = 3; i >= 0; i--) exp_tx_q.push_back('{d[8*i +: 8], (i == 0)});
        end
        uart_send(8'h52, 1'b1);
        send_word(a);
        wait_idle();
    endtask

    task automatic do_bad(input logic [7:0] c);
        exp_tx_q.push_back('{8'h15, 1'b1});
        uart_send(c, 1'b1);
        wait_idle();
    endtask

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_stb", 32'(stb), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_data", wdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        do_write(32'h10000005, 32'h00000041);
        check("addr_holds", addr, 32'h10000005);
        check("data_holds", wdata, 32'h00000041);
        do_read(32'h10000005, 3, 32'h000000AB);
        do_read(32'h40000000, -1, 32'h0);
        do_bad(8'h41);
        do_write(32'h20000100, 32'hDEADBEEF);

        uart_send(8'h57, 1'b1);
        check("busy_after_cmd", 32'(busy), 32'h1);
        uart_send(8'h10, 1'b0);
        repeat (20) @(negedge clk);
        check("busy_after_ferr", 32'(busy), 32'h0);
        do_read(32'h30000004, 2, 32'h12345678);
        do_read(32'h30000008, 0, 32'h9ABCDEF0);

        rd_lat = -1;
        exp_bus_q.push_back('{1'b0, 32'hCAFE0010, 32'h0, 0});
        uart_send(8'h52, 1'b1);
        send_word(32'hCAFE0010);
        n = 0;
        while (stb !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rd_stb_seen", 32'(stb), 32'h1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_stb", 32'(stb), 32'h0);
        check("abort_tx", 32'(tx), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_addr", addr, 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        do_write(32'h00000FF0, 32'h5A5AA5A5);

        for (int k = 0; k < 12; k++) begin
            int          kind;
            logic [31:0] a, d;
            logic [7:0]  c;
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            d    = $urandom;
            case (kind)
                0: do_write(a, d);
                1: do_read(a, int'($urandom_range(0, 5)), d);
                2: do_read(a, -1, d);
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h57 || c == 8'h52) c = 8'h00;
                    do_bad(c);
                end
            endcase
        end

        check("bus_queue_drained", 32'(exp_bus_q.size()), 32'h0);
        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
